// File: rtl/kmeans_pkg.sv
// Shared k-means definitions: sequencer state encoding and width helpers used by
// the assignment controller, distance unit and centroid-update block.
package kmeans_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LD   = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } kmeans_state_e;

  localparam int K_DEF    = 8;
  localparam int D_DEF    = 4;
  localparam int W_DEF    = 8;
  localparam int NMAX_DEF = 1024;

  // Width of a cluster label; a single cluster still needs one bit of port.
  function automatic int lbl_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  function automatic int addr_width(input int nmax);
    return (nmax > 1) ? $clog2(nmax) : 1;
  endfunction

endpackage

// File: rtl/kmeans_change_counter.sv
// Counts labels that differ from the previous pass; saturating at NMAX.
// Only instantiated when KMEANS_CHANGE_CNT_EN is defined.
module kmeans_change_counter
  import kmeans_pkg::*;
#(
  parameter int LW   = lbl_width(K_DEF),
  parameter int AW   = addr_width(NMAX_DEF),
  parameter int NMAX = NMAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          cap_i,
  input  logic [LW-1:0] prev_i,
  input  logic          cmp_i,
  input  logic [LW-1:0] new_i,
  output logic [AW:0]   cnt_o
);

  logic [LW-1:0] prev_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (cap_i) prev_q <= prev_i;
      if (clr_i) begin
        cnt_q <= '0;
      end else if (cmp_i && (new_i != prev_q) && (cnt_q != (AW+1)'(NMAX))) begin
        cnt_q <= cnt_q + (AW+1)'(1);
      end
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/kmeans_assign_ctrl.sv
// k-means assignment sequencer: point read -> distance unit -> label write, 3 cycles/point.
// Optional label-change counting is enabled with the KMEANS_CHANGE_CNT_EN macro.
module kmeans_assign_ctrl
  import kmeans_pkg::*;
#(
  parameter  int K    = K_DEF,
  parameter  int D    = D_DEF,
  parameter  int W    = W_DEF,
  parameter  int NMAX = NMAX_DEF,
  localparam int LW   = lbl_width(K),
  localparam int AW   = addr_width(NMAX),
  localparam int PW   = D * W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   n_points,
  output logic          busy,
  output logic          done,
  output logic          pt_rd_en,
  output logic [AW-1:0] pt_rd_addr,
  input  logic [PW-1:0] pt_rd_data,
  output logic [PW-1:0] du_point_flat,
  input  logic [LW-1:0] du_min_cluster,
  output logic          lbl_wr_en,
  output logic [AW-1:0] lbl_wr_addr,
  output logic [LW-1:0] lbl_wr_data,
  output logic          lbl_rd_en,
  input  logic [LW-1:0] lbl_rd_data,
  output logic [AW:0]   changed_cnt
);

  kmeans_state_e state_q;
  logic [AW:0]   n_q;
  logic [AW-1:0] idx_q;
  logic [PW-1:0] point_q;
  logic          busy_q;
  logic          done_q;
  logic          pt_rd_en_q;
  logic          lbl_wr_en_q;

  logic accept;
  logic last_pt;

  assign accept  = (state_q == ST_IDLE) && start;
  assign last_pt = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));

  // Outputs are registered alongside the state: each strobe is set on the edge
  // that enters the state owning it, so it is high for exactly that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      point_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pt_rd_en_q  <= 1'b0;
      lbl_wr_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      done_q      <= 1'b0;
      pt_rd_en_q  <= 1'b0;
      lbl_wr_en_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_q    <= n_points;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (n_points == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_RD;
              pt_rd_en_q <= 1'b1;
            end
          end
        end
        ST_RD: state_q <= ST_LD;
        ST_LD: begin
          point_q     <= pt_rd_data;
          state_q     <= ST_WR;
          lbl_wr_en_q <= 1'b1;
        end
        ST_WR: begin
          if (last_pt) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
          end else begin
            idx_q      <= idx_q + AW'(1);
            state_q    <= ST_RD;
            pt_rd_en_q <= 1'b1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pt_rd_en      = pt_rd_en_q;
  assign pt_rd_addr    = idx_q;
  assign du_point_flat = point_q;
  assign lbl_wr_en     = lbl_wr_en_q;
  assign lbl_wr_addr   = idx_q;
  // The winner is only valid once du_point_flat is loaded, i.e. in WR itself.
  assign lbl_wr_data   = lbl_wr_en_q ? du_min_cluster : '0;

`ifdef KMEANS_CHANGE_CNT_EN
  // Previous label shares the point read strobe and address.
  assign lbl_rd_en = pt_rd_en_q;

  kmeans_change_counter #(
    .LW   (LW),
    .AW   (AW),
    .NMAX (NMAX)
  ) u_change_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .cap_i  (state_q == ST_LD),
    .prev_i (lbl_rd_data),
    .cmp_i  (state_q == ST_WR),
    .new_i  (du_min_cluster),
    .cnt_o  (changed_cnt)
  );
`else
  logic unused_lbl_rd;
  assign unused_lbl_rd = ^{lbl_rd_data, accept};
  assign lbl_rd_en     = 1'b0;
  assign changed_cnt   = '0;
`endif

endmodule

// File: tb/tb_kmeans_assign_ctrl.sv
// Self-checking bench for kmeans_assign_ctrl: memory models, a stand-in distance
// unit (label = low bits of coordinate 0) and a write scoreboard.
module tb_kmeans_assign_ctrl;

  localparam int K    = 8;
  localparam int D    = 4;
  localparam int W    = 8;
  localparam int NMAX = 1024;
  localparam int LW   = 3;
  localparam int AW   = 10;
  localparam int PW   = D * W;
`ifdef KMEANS_CHANGE_CNT_EN
  localparam bit CHG_ON = 1'b1;
`else
  localparam bit CHG_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW:0]   n_points;
  logic          busy;
  logic          done;
  logic          pt_rd_en;
  logic [AW-1:0] pt_rd_addr;
  logic [PW-1:0] pt_rd_data;
  logic [PW-1:0] du_point_flat;
  logic [LW-1:0] du_min_cluster;
  logic          lbl_wr_en;
  logic [AW-1:0] lbl_wr_addr;
  logic [LW-1:0] lbl_wr_data;
  logic          lbl_rd_en;
  logic [LW-1:0] lbl_rd_data;
  logic [AW:0]   changed_cnt;

  kmeans_assign_ctrl #(.K(K), .D(D), .W(W), .NMAX(NMAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .n_points       (n_points),
    .busy           (busy),
    .done           (done),
    .pt_rd_en       (pt_rd_en),
    .pt_rd_addr     (pt_rd_addr),
    .pt_rd_data     (pt_rd_data),
    .du_point_flat  (du_point_flat),
    .du_min_cluster (du_min_cluster),
    .lbl_wr_en      (lbl_wr_en),
    .lbl_wr_addr    (lbl_wr_addr),
    .lbl_wr_data    (lbl_wr_data),
    .lbl_rd_en      (lbl_rd_en),
    .lbl_rd_data    (lbl_rd_data),
    .changed_cnt    (changed_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0]    pt_mem    [NMAX];
  logic [LW-1:0]    lbl_mem   [NMAX];
  logic [LW-1:0]    model_lbl [NMAX];
  logic [AW+LW-1:0] exp_q     [$];
  int               lbl_plan  [$];
  int               exp_chg;
  logic [PW-1:0]    last_pt;
  int               rd_cnt;
  int               wr_cnt;
  logic [AW-1:0]    last_wr_addr;

  // Registered-read memories
  always @(posedge clk) begin
    if (pt_rd_en)  pt_rd_data <= pt_mem[pt_rd_addr];
    if (lbl_rd_en) lbl_rd_data <= lbl_mem[pt_rd_addr];
    if (lbl_wr_en) lbl_mem[lbl_wr_addr] <= lbl_wr_data;
  end

  assign du_min_cluster = du_point_flat[LW-1:0];

  // Scoreboard: every label write is popped against the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (pt_rd_en) rd_cnt++;
      if (lbl_wr_en) begin
        logic [AW+LW-1:0] exp;
        wr_cnt++;
        last_wr_addr = lbl_wr_addr;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_write: got addr %0d data %0d, expected no write",
                   lbl_wr_addr, lbl_wr_data);
        end else begin
          exp = exp_q.pop_front();
          if ({lbl_wr_addr, lbl_wr_data} !== exp) begin
            errors++;
            $display("FAIL sb_write: got addr %0d data %0d, expected addr %0d data %0d",
                     lbl_wr_addr, lbl_wr_data, exp[AW+LW-1:LW], exp[LW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Fill points 0..n-1 and queue the expected writes for the first push_n of them.
  task automatic load_points(input int n, input int push_n);
    logic [LW-1:0] l;
    logic [PW-1:0] word;
    exp_chg = 0;
    for (int i = 0; i < n; i++) begin
      l = (i < lbl_plan.size()) ? LW'(lbl_plan[i]) : LW'($urandom_range(0, K-1));
      word = PW'($urandom);
      word[LW-1:0] = l;
      pt_mem[i] = word;
      last_pt = word;
      if (i < push_n) begin
        exp_q.push_back({AW'(i), l});
        if (l != model_lbl[i]) exp_chg++;
        model_lbl[i] = l;
      end
    end
    lbl_plan.delete();
  endtask

  // Launch a pass and count cycles (start cycle = 0) until done; -1 on timeout.
  task automatic run_pass(input int n, input int budget, input int repulse_at, output int lat);
    rd_cnt = 0;
    wr_cnt = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    n_points = (AW+1)'(n);
    lat      = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start    = (c == repulse_at);
      n_points = (AW+1)'(n + 3 + c);
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    n_points = '0;
    pt_rd_data = '0;
    lbl_rd_data = '0;
    rd_cnt = 0;
    wr_cnt = 0;
    for (int i = 0; i < NMAX; i++) begin
      lbl_mem[i] = '0;
      model_lbl[i] = '0;
    end
    #3;
    checks++;
    if ({busy, done, pt_rd_en, lbl_wr_en, lbl_rd_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, expected 00000", {busy, done, pt_rd_en, lbl_wr_en, lbl_rd_en});
    end
    checks++;
    if ({pt_rd_addr, lbl_wr_addr, lbl_wr_data, du_point_flat, changed_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %0d/%0d data %0d point %h cnt %0d, expected all 0",
               pt_rd_addr, lbl_wr_addr, lbl_wr_data, du_point_flat, changed_cnt);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rd_cnt != 0 || wr_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: rd %0d wr %0d busy %b, expected 0 0 0", rd_cnt, wr_cnt, busy);
    end
  endtask

  task automatic test_four_points;
    int lat;
    lbl_plan = '{3, 1, 0, 7};
    load_points(4, 4);
    run_pass(4, 40, 0, lat);
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL four_latency: got %0d, expected 13", lat);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL four_busy_at_done: got %b, expected 1", busy);
    end
    checks++;
    if (changed_cnt !== (AW+1)'(CHG_ON ? exp_chg : 0)) begin
      errors++;
      $display("FAIL four_changed: got %0d, expected %0d", changed_cnt, CHG_ON ? exp_chg : 0);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL four_after_done: done %b busy %b, expected 0 0", done, busy);
    end
    checks++;
    if (du_point_flat !== last_pt) begin
      errors++;
      $display("FAIL four_point_hold: got %h, expected %h", du_point_flat, last_pt);
    end
    checks++;
    if (exp_q.size() != 0 || wr_cnt != 4 || rd_cnt != 4) begin
      errors++;
      $display("FAIL four_counts: pending %0d wr %0d rd %0d, expected 0 4 4", exp_q.size(), wr_cnt, rd_cnt);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (changed_cnt !== (AW+1)'(CHG_ON ? exp_chg : 0)) begin
      errors++;
      $display("FAIL four_changed_hold: got %0d, expected %0d", changed_cnt, CHG_ON ? exp_chg : 0);
    end
  endtask

  task automatic test_zero_points;
    int lat;
    run_pass(0, 10, 0, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL zero_latency: got %0d, expected 1", lat);
    end
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (rd_cnt != 0 || wr_cnt != 0 || busy !== 1'b0 || changed_cnt !== '0) begin
      errors++;
      $display("FAIL zero_no_strobes: rd %0d wr %0d busy %b cnt %0d, expected 0 0 0 0",
               rd_cnt, wr_cnt, busy, changed_cnt);
    end
  endtask

  task automatic test_restart_ignored;
    int lat;
    load_points(4, 4);
    run_pass(4, 40, 5, lat);
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL restart_latency: got %0d, expected 13", lat);
    end
    repeat (6) @(posedge clk); #1;
    checks++;
    if (wr_cnt != 4 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_writes: wr %0d pending %0d busy %b, expected 4 0 0", wr_cnt, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid_pass;
    bit found;
    load_points(4, 2);
    rd_cnt = 0;
    wr_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    n_points = (AW+1)'(4);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (lbl_wr_en && lbl_wr_addr == AW'(2)) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst_reach_wr2: got no WR of point 2, expected one");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, pt_rd_en, lbl_wr_en, lbl_rd_en, lbl_wr_data, du_point_flat, pt_rd_addr, changed_cnt} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: busy %b wr_en %b data %0d point %h addr %0d, expected all 0",
               busy, lbl_wr_en, lbl_wr_data, du_point_flat, pt_rd_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    checks++;
    if (wr_cnt != 2 || rd_cnt != 3 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_aborted: wr %0d rd %0d pending %0d busy %b, expected 2 3 0 0",
               wr_cnt, rd_cnt, exp_q.size(), busy);
    end
  endtask

  task automatic test_changed_count;
    int lat;
    for (int i = 0; i < 4; i++) begin
      lbl_mem[i] = '0;
      model_lbl[i] = '0;
    end
    lbl_plan = '{0, 2, 0, 5};
    load_points(4, 4);
    run_pass(4, 40, 0, lat);
    checks++;
    if (changed_cnt !== (AW+1)'(CHG_ON ? 2 : 0) || lat != 13) begin
      errors++;
      $display("FAIL changed_cnt: got %0d (lat %0d), expected %0d (lat 13)", changed_cnt, lat, CHG_ON ? 2 : 0);
    end
  endtask

  task automatic test_back_to_back;
    int lat1;
    int lat2;
    load_points(2, 2);
    run_pass(2, 20, 0, lat1);
    load_points(3, 3);
    run_pass(3, 20, 0, lat2);
    checks++;
    if (lat1 != 7 || lat2 != 10) begin
      errors++;
      $display("FAIL b2b_latency: got %0d/%0d, expected 7/10", lat1, lat2);
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || wr_cnt != 3 || du_point_flat !== last_pt) begin
      errors++;
      $display("FAIL b2b_writes: pending %0d wr %0d point %h, expected 0 3 %h",
               exp_q.size(), wr_cnt, du_point_flat, last_pt);
    end
  endtask

  task automatic test_nmax;
    int lat;
    load_points(NMAX, NMAX);
    run_pass(NMAX, 3 * NMAX + 50, 0, lat);
    checks++;
    if (lat != 3 * NMAX + 1) begin
      errors++;
      $display("FAIL nmax_latency: got %0d, expected %0d", lat, 3 * NMAX + 1);
    end
    checks++;
    if (changed_cnt !== (AW+1)'(CHG_ON ? exp_chg : 0)) begin
      errors++;
      $display("FAIL nmax_changed: got %0d, expected %0d", changed_cnt, CHG_ON ? exp_chg : 0);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (wr_cnt != NMAX || rd_cnt != NMAX || last_wr_addr !== AW'(NMAX - 1) || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nmax_end: wr %0d rd %0d last %0d pending %0d busy %b, expected %0d %0d %0d 0 0",
               wr_cnt, rd_cnt, last_wr_addr, exp_q.size(), busy, NMAX, NMAX, NMAX - 1);
    end
  endtask

  initial begin
    test_reset();
    test_four_points();
    test_zero_points();
    test_restart_ignored();
    test_reset_mid_pass();
    test_changed_count();
    test_back_to_back();
    test_nmax();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
